// File: rtl/mux_sel_sequencer_if.sv
// Mux-facing bus of the select sequencer: data and select toward a 4:1 mux,
// and the mux output fed back.
interface mux_sel_sequencer_if;
    logic [3:0] a_out;
    logic [1:0] s_out;
    logic       mux_o;

    modport master (output a_out, output s_out, input mux_o);
    modport slave  (input a_out, input s_out, output mux_o);
endinterface

// File: rtl/mux_sel_sequencer.sv
// Drives a 4:1 mux with a latched word, steps the select 0..3 with a
// programmable dwell, and rebuilds the word from the sampled mux output.
module mux_sel_sequencer #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [3:0]         load_data,
    input  logic [DWELL_W-1:0] dwell,
    mux_sel_sequencer_if.master mux,
    output logic               busy,
    output logic               done,
    output logic [3:0]         word,
    output logic               word_valid
);

    localparam logic [DWELL_W-1:0] DW_ZERO = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] DW_ONE  = {{(DWELL_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r, state_s;
    logic [3:0]         a_r, a_s;
    logic [1:0]         sel_r, sel_s;
    logic [DWELL_W-1:0] cnt_r, cnt_s;
    logic [DWELL_W-1:0] eff_r, eff_s;
    logic [3:0]         word_r, word_s;
    logic               wv_r, wv_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;

    // Next-state and next-output computation for the scan sequencer.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        sel_s   = sel_r;
        cnt_s   = cnt_r;
        eff_s   = eff_r;
        word_s  = word_r;
        wv_s    = wv_r;
        busy_s  = busy_r;
        done_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    a_s     = load_data;
                    eff_s   = (dwell == DW_ZERO) ? DW_ONE : dwell;
                    sel_s   = 2'd0;
                    cnt_s   = DW_ZERO;
                    wv_s    = 1'b0;
                    busy_s  = 1'b1;
                    state_s = ST_SCAN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SCAN: begin
                // Last dwell cycle of this select: the mux output has settled.
                if (cnt_r == (eff_r - DW_ONE)) begin
                    word_s[sel_r] = mux.mux_o;
                    cnt_s         = DW_ZERO;
                    if (sel_r == 2'd3) begin
                        state_s = ST_DONE;
                        done_s  = 1'b1;
                        wv_s    = 1'b1;
                    end else begin
                        sel_s = sel_r + 2'd1;
                    end
                end else begin
                    cnt_s = cnt_r + DW_ONE;
                end
            end
            ST_DONE: begin
                busy_s  = 1'b0;
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            a_r     <= 4'd0;
            sel_r   <= 2'd0;
            cnt_r   <= DW_ZERO;
            eff_r   <= DW_ONE;
            word_r  <= 4'd0;
            wv_r    <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            a_r     <= a_s;
            sel_r   <= sel_s;
            cnt_r   <= cnt_s;
            eff_r   <= eff_s;
            word_r  <= word_s;
            wv_r    <= wv_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign mux.a_out  = a_r;
    assign mux.s_out  = sel_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign word       = word_r;
    assign word_valid = wv_r;

endmodule

// File: tb/tb_mux_sel_sequencer.sv
// Directed bench for mux_sel_sequencer with a behavioural 4:1 mux in loopback
// and an optional inverting fault on the fed-back output.
module tb_mux_sel_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] load_data;
    logic [3:0] dwell;
    logic       busy, done, word_valid;
    logic [3:0] word;
    logic       fault;

    int total = 0;
    int bad   = 0;

    mux_sel_sequencer_if bus ();

    assign bus.mux_o = fault ^ bus.a_out[bus.s_out];

    mux_sel_sequencer #(.DWELL_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_data  (load_data),
        .dwell      (dwell),
        .mux        (bus),
        .busy       (busy),
        .done       (done),
        .word       (word),
        .word_valid (word_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] ld;
        logic [3:0] dw;
        logic       flt;
        logic [3:0] expw;
        int         eff;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " a_out"}, 32'(bus.a_out), 32'd0);
        chk({tag, " s_out"}, 32'(bus.s_out), 32'd0);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " word"}, 32'(word), 32'd0);
        chk({tag, " word_valid"}, 32'(word_valid), 32'd0);
    endtask

    // Called at a negedge; start is accepted at the following posedge (E0).
    // Iteration j observes the state right after edge E0+j.
    task automatic run_scan(input logic [3:0] ld, input logic [3:0] dw, input logic flt,
                            input logic [3:0] expw, input int eff, input bit poke);
        int sexp;
        fault     = flt;
        load_data = ld;
        dwell     = dw;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int j = 0; j <= 4 * eff + 1; j++) begin
            if (j > 0) @(negedge clk);
            if (poke && j == 2) begin
                start     = 1'b1;
                load_data = 4'b0011;
                dwell     = 4'd2;
            end else if (poke && j == 3) begin
                start = 1'b0;
            end
            sexp = (j / eff > 3) ? 3 : j / eff;
            chk("s_out", 32'(bus.s_out), 32'(sexp));
            chk("a_out", 32'(bus.a_out), 32'(ld));
            chk("done", 32'(done), (j == 4 * eff) ? 32'd1 : 32'd0);
            chk("busy", 32'(busy), (j <= 4 * eff) ? 32'd1 : 32'd0);
            if (j == 0) chk("word_valid cleared", 32'(word_valid), 32'd0);
            if (j >= 4 * eff) begin
                chk("word", 32'(word), 32'(expw));
                chk("word_valid", 32'(word_valid), 32'd1);
            end
        end
        repeat (3) begin
            @(negedge clk);
            chk("idle done", 32'(done), 32'd0);
            chk("idle busy", 32'(busy), 32'd0);
            chk("idle a_out", 32'(bus.a_out), 32'(ld));
        end
        fault = 1'b0;
    endtask

    initial begin
        vecs[0] = '{ld: 4'b1010, dw: 4'd1,  flt: 1'b0, expw: 4'b1010, eff: 1};
        vecs[1] = '{ld: 4'b0110, dw: 4'd3,  flt: 1'b0, expw: 4'b0110, eff: 3};
        vecs[2] = '{ld: 4'b1001, dw: 4'd0,  flt: 1'b0, expw: 4'b1001, eff: 1};
        vecs[3] = '{ld: 4'b1010, dw: 4'd2,  flt: 1'b1, expw: 4'b0101, eff: 2};
        vecs[4] = '{ld: 4'b0011, dw: 4'd15, flt: 1'b0, expw: 4'b0011, eff: 15};

        rst       = 1'b1;
        start     = 1'b0;
        load_data = 4'd0;
        dwell     = 4'd0;
        fault     = 1'b0;
        #2;
        chk_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_zero("after reset");

        for (int v = 0; v < 5; v++) begin
            run_scan(vecs[v].ld, vecs[v].dw, vecs[v].flt, vecs[v].expw, vecs[v].eff, 1'b0);
        end

        // Second start during SCAN must be ignored and not queued.
        run_scan(4'b1100, 4'd2, 1'b0, 4'b1100, 2, 1'b1);

        // Asynchronous reset while s_out==2.
        load_data = 4'b0110;
        dwell     = 4'd2;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int n = 0;
            while (bus.s_out != 2'd2 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("reach s_out==2", 32'(bus.s_out), 32'd2);
        end
        #2 rst = 1'b1;
        #1 chk_zero("async reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (10) begin
            @(negedge clk);
            chk("post reset done", 32'(done), 32'd0);
            chk("post reset busy", 32'(busy), 32'd0);
        end

        // rst and start together: rst wins.
        rst       = 1'b1;
        start     = 1'b1;
        load_data = 4'b1111;
        dwell     = 4'd1;
        @(negedge clk);
        chk("rst+start busy", 32'(busy), 32'd0);
        chk("rst+start a_out", 32'(bus.a_out), 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst+start idle busy", 32'(busy), 32'd0);

        run_scan(4'b1111, 4'd1, 1'b0, 4'b1111, 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_sel_sequencer.md
Name: mux_sel_sequencer

Overview:
- Upstream driver for the 4:1 mux block (4-bit data a, 2-bit select s, 1-bit output o).
- On a start request it latches a 4-bit word, presents it on the mux data inputs, and steps the select through 0,1,2,3, holding each value for a programmable dwell.
- At the end of each dwell it samples the mux output back and rebuilds the word, then reports completion.
- It gives the mux an automatic self-check and scan source in place of hand-driven select stimulus.

Parameters:
- DWELL_W, 4, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  scan request; sampled only in IDLE.
- load_data  input  4  word to present to the mux; latched when start is accepted.
- dwell  input  DWELL_W  cycles each select value is held; latched when start is accepted; 0 treated as 1.
- mux_o  input  1  mux output fed back (combinational from a_out/s_out).
- a_out  output  4  mux data inputs (connect to a).
- s_out  output  2  mux select (connect to s).
- busy  output  1  high from the cycle after start is accepted until DONE is exited.
- done  output  1  one-cycle pulse when the scan completes.
- word  output  4  reconstructed word; bit k = mux_o sampled while s_out==k.
- word_valid  output  1  high after a completed scan; cleared when the next start is accepted.

Behaviour:
- Reset (async, immediate): state=IDLE; a_out=0, s_out=0, busy=0, done=0, word=0, word_valid=0, dwell counter=0, latched dwell=1.
- States: IDLE, SCAN, DONE.
- IDLE:
  - If start=1 at edge: a_out<=load_data; dwell_eff<=(dwell==0 ? 1 : dwell); s_out<=0; cnt<=0; word_valid<=0; busy<=1; go to SCAN.
  - Otherwise hold all outputs.
- SCAN, each edge:
  - If cnt==dwell_eff-1: word[s_out]<=mux_o; cnt<=0. Then, if s_out==3, go to DONE; else s_out<=s_out+1.
  - Otherwise cnt<=cnt+1.
  - Sampling uses mux_o in the last dwell cycle of each select value. The mux is combinational, so the sampled value is settled.
- DONE, one cycle only:
  - done=1, word_valid<=1, busy<=0 on exit; go to IDLE.
  - s_out and a_out hold their last values (s_out=3, latched word) until the next accepted start.
- Latency: start accepted at edge E0. s_out=0 is visible after E0. Each select value is held dwell_eff cycles. DONE is entered at edge E0+4*dwell_eff, and done is high for the cycle after it. IDLE is re-entered at E0+4*dwell_eff+1.
- done is a registered output (state==DONE). word is stable and word_valid=1 in the same cycle done is high.
- start while busy (SCAN or DONE): ignored, no effect on a_out, dwell_eff, or counters. It is not queued.
- Changes to load_data or dwell during SCAN: no effect. Only the latched copies are used.
- Counter wrap: cnt never exceeds dwell_eff-1. Maximum dwell_eff = 2^DWELL_W-1 (15 at default).
- Reset mid-SCAN: immediate return to IDLE with all reset values. A partial word is discarded, and done is not asserted.
- Simultaneous rst and start: rst wins.

Test Plan:
- Loopback with a real mux instance, load_data=4'b1010, dwell=1, start pulsed one cycle:
  - s_out steps 0,1,2,3, one cycle each.
  - done pulses 5 cycles after the start edge.
  - word=4'b1010, word_valid=1, busy low after done.
- Loopback, load_data=4'b0110, dwell=3:
  - Each s_out value is held exactly 3 cycles.
  - done appears 13 cycles after start.
  - word=4'b0110.
- dwell=0, load_data=4'b1001: timing identical to dwell=1 (done at +5), word=4'b1001.
- Fault injection: mux_o driven as the inverse of the true mux output, load_data=4'b1010, dwell=2 → word=4'b0101.
- Busy rejection: start with load_data=4'b1100, dwell=2; during SCAN pulse start again with load_data=4'b0011.
  - Only one done pulse occurs, at +9.
  - word=4'b1100, a_out unchanged.
- Reset mid-scan: assert rst asynchronously at s_out==2.
  - All outputs are 0 immediately; no done pulse.
  - A subsequent start with 4'b1111, dwell=1 completes normally with word=4'b1111.
